demux1to4_fifo: RTL and testbench
=================================

# demux1to4_fifo

Buffered 1-to-4 demultiplexer: the steering counterpart of the 4-to-1 data mux. It accepts one `dwidth`-bit word per cycle on a valid/ready input, plus a 2-bit channel select. The word is written into a 2-entry FIFO owned by the selected output channel. Each of the four channels drains independently through its own valid/ready handshake. It sits between a single producer, such as a packet-field extractor, and four per-port consumers in the ethernet datapath, so a stalled consumer back-pressures only traffic addressed to it.

## Interface
- `dwidth`, default 2: data word width in bits, ≥1.
- `clk`  in  1  rising-edge clock, single clock domain.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `in_valid`  in  1  producer presents a word this cycle.
- `in_ready`  out  1  block accepts the word this cycle.
- `in_sel`  in  2  destination channel of the presented word (0..3).
- `in_data`  in  dwidth  presented word.
- `out_valid`  out  4  bit i: channel i FIFO non-empty.
- `out_ready`  in  4  bit i: consumer i takes the head word this cycle.
- `out_data0`..`out_data3`  out  dwidth each  head word of channel 0..3.
- `occ0`..`occ3`  out  2 each  registered occupancy of channel 0..3 (0, 1 or 2).

## Operation
- Each channel i holds two storage words `mem_i[0:1]`, a 1-bit write pointer `wp_i`, a 1-bit read pointer `rp_i` and a 2-bit count `cnt_i`.
- `in_ready = (cnt[in_sel] != 2)`.
  - The value is purely combinational from registered counts and `in_sel`.
  - It never depends on `out_ready`. There is no full-FIFO bypass.
- Accept: `in_valid & in_ready`.
  - On accept, `mem_s[wp_s] <= in_data`, `wp_s` toggles, where s = `in_sel`.
  - Nothing else is written.
- Drain channel i: `out_valid[i] & out_ready[i]`.
  - On drain, `rp_i` toggles.
  - `out_ready[i]` while `out_valid[i]`=0 is ignored.
- Count update per channel:
  - +1 on accept-only.
  - −1 on drain-only.
  - Unchanged on both or neither.
  - Never exceeds 2 and never wraps below 0.
- `out_valid[i] = (cnt_i != 0)`, `out_data_i = mem_i[rp_i]`, `occ_i = cnt_i`. All are driven directly from registers.
- `out_data_i` holds its value while `out_valid[i]` is high and `out_ready[i]` is low.
  - It is stable until drained.
- Words on the same channel exit in acceptance order.
  - No ordering is guaranteed across channels.
- `in_sel` and `in_data` are don't-care when `in_valid`=0.
  - A full destination leaves `in_ready`=0. The producer must hold `in_data`/`in_sel` until accepted. The block does not re-check them.
- Simultaneous events:
  - Accept into channel i and drain of channel i in the same cycle with `cnt_i`=1: count stays 1, pointers both toggle.
  - With `cnt_i`=0, the accept proceeds and there is no drain (`out_valid` low).
  - Drains on all four channels plus one accept may occur in the same cycle.

## Timing
- Reset, asynchronous assert:
  - All `cnt_i`=0, `wp_i`=`rp_i`=0, all `mem` words = 0.
  - Hence `out_valid`=4'b0000, `out_data0..3`=0, `occ0..3`=0, `in_ready`=1.
  - Release is synchronous to the next `clk` edge.
- Reset mid-operation: all buffered words are discarded, with no partial drain. A handshake in the reset cycle has no effect.
- Latency: a word accepted at edge N appears on `out_valid`/`out_data` after edge N; it can be drained at edge N+1.
  - Minimum in-to-out latency is one cycle.
- Throughput: one word per cycle into any channel whose consumer holds `out_ready` high.
  - The steady state is `cnt`=1.
- A channel held at `out_ready`=0 fills after exactly 2 accepts; `in_ready` drops for that `in_sel` only.
- Critical path: `in_sel` → 4:1 mux of counts → `in_ready`. There is no `out_ready`→`in_ready` path.

## Test plan
- Reset check:
  - Assert `reset` mid-cycle with `clk` stopped.
  - Required: `out_valid`=0000, `occ0..3`=0, `out_data0..3`=0, `in_ready`=1 immediately.
- Steering order:
  - Send 3,1,2,0 on `in_data` with `in_sel`=0,1,2,3 (`dwidth`=2), all `out_ready`=0.
  - Required: `out_data0`=3, `out_data1`=1, `out_data2`=2, `out_data3`=0.
  - Required: all `occ`=1, `out_valid`=1111 one cycle after each accept.
- Full/back-pressure:
  - Write 1 then 2 to channel 2 with `out_ready[2]`=0.
  - Required: `occ2`=2, `in_ready`=0 while `in_sel`=2, `in_ready`=1 while `in_sel`=0.
  - Then raise `out_ready[2]` for two cycles.
  - Required: outputs 1 then 2, `occ2` 2→1→0, `out_valid[2]` falls.
- Simultaneous accept+drain:
  - Channel 1 at `cnt`=1 holding 2; accept 3 to channel 1 with `out_ready[1]`=1.
  - Required: 2 is drained, `occ1` stays 1, `out_data1`=3 next cycle.
- Streaming:
  - 16 back-to-back words to channel 3 with `out_ready[3]` held high.
  - Required: `in_valid&in_ready` every cycle, output sequence identical and one cycle delayed, `occ3` never exceeds 1.
- Reset mid-stream:
  - Channels 0 and 2 at `occ`=2; assert `reset` for one cycle.
  - Required: all `occ`=0, no further `out_valid`, the next accepted word is the first to appear.

Source files
------------

// File: rtl/demux1to4_fifo.sv
// demux1to4_fifo: steers each input word into one of four independent 2-deep per-channel FIFOs
module demux1to4_fifo #(
  parameter int dwidth = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_sel,
  input  logic [dwidth-1:0] in_data,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [dwidth-1:0] out_data0,
  output logic [dwidth-1:0] out_data1,
  output logic [dwidth-1:0] out_data2,
  output logic [dwidth-1:0] out_data3,
  output logic [1:0]        occ0,
  output logic [1:0]        occ1,
  output logic [1:0]        occ2,
  output logic [1:0]        occ3
);
  logic [3:0][1:0]        cnt;
  logic [3:0][dwidth-1:0] head;
  assign in_ready  = cnt[in_sel] != 2'd2;
  assign out_data0 = head[0];
  assign out_data1 = head[1];
  assign out_data2 = head[2];
  assign out_data3 = head[3];
  assign occ0      = cnt[0];
  assign occ1      = cnt[1];
  assign occ2      = cnt[2];
  assign occ3      = cnt[3];
  for (genvar i = 0; i < 4; i++) begin : g_ch
    logic [dwidth-1:0] mem [2];
    logic              wp, rp, acc, drn;
    logic [1:0]        c;
    assign acc          = in_valid & in_ready & (in_sel == 2'(i));
    assign drn          = (c != 2'd0) & out_ready[i];
    assign cnt[i]       = c;
    assign head[i]      = mem[rp];
    assign out_valid[i] = c != 2'd0;
    // Channel FIFO: write at wp on accept, advance rp on drain, count follows the net change
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        mem[0] <= '0;
        mem[1] <= '0;
        wp     <= 1'b0;
        rp     <= 1'b0;
        c      <= 2'd0;
      end else begin
        if (acc) mem[wp] <= in_data;
        wp <= wp ^ acc;
        rp <= rp ^ drn;
        c  <= (acc & ~drn) ? c + 2'd1 : (drn & ~acc) ? c - 2'd1 : c;
      end
    end
  end
endmodule

// File: tb/tb_demux1to4_fifo.sv
// tb_demux1to4_fifo: directed stimulus with per-channel scoreboard queues checked by a negedge monitor
module tb_demux1to4_fifo;
  logic       clk = 1'b0;
  logic       run = 1'b1;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_sel = 2'd0;
  logic [1:0] in_data = 2'd0;
  logic [3:0] out_valid;
  logic [3:0] out_ready = 4'd0;
  logic [1:0] out_data0, out_data1, out_data2, out_data3;
  logic [1:0] occ0, occ1, occ2, occ3;
  logic [1:0] od [4];
  logic [1:0] oc [4];
  int         expq [4][$];
  int         mcnt [4];
  int         n_checks = 0;
  int         n_fail = 0;

  demux1to4_fifo #(.dwidth(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
    .occ0(occ0), .occ1(occ1), .occ2(occ2), .occ3(occ3)
  );

  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;
  assign oc[0] = occ0;
  assign oc[1] = occ1;
  assign oc[2] = occ2;
  assign oc[3] = occ3;

  always #5 if (run) clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input int ch, input int d);
    in_valid = 1'b1;
    in_sel   = 2'(ch);
    in_data  = 2'(d);
    expq[ch].push_back(d);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT against the occupancy model and the expected-word queues, then advance the model
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        mcnt[i] = 0;
        expq[i].delete();
      end
    end else begin
      chk("in_ready", int'(in_ready), int'(mcnt[in_sel] != 2));
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("occ%0d", i), int'(oc[i]), mcnt[i]);
        chk($sformatf("out_valid%0d", i), int'(out_valid[i]), int'(mcnt[i] != 0));
        if (mcnt[i] != 0) begin
          if (expq[i].size() == 0) chk($sformatf("scoreboard_empty%0d", i), 1, 0);
          else chk($sformatf("out_data%0d", i), int'(od[i]), expq[i][0]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        automatic bit a = in_valid && in_sel == 2'(i) && mcnt[i] != 2;
        automatic bit d = mcnt[i] != 0 && out_ready[i];
        if (d && expq[i].size() != 0) void'(expq[i].pop_front());
        mcnt[i] = mcnt[i] + int'(a) - int'(d);
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    step(1);
    reset = 1'b0;
    // steering: each channel gets one distinct word
    send(0, 3);
    send(1, 1);
    send(2, 2);
    send(3, 0);
    chk("steer_d0", int'(out_data0), 3);
    chk("steer_d1", int'(out_data1), 1);
    chk("steer_d2", int'(out_data2), 2);
    chk("steer_d3", int'(out_data3), 0);
    chk("steer_valid", int'(out_valid), 15);
    out_ready = 4'hf;
    step(1);
    out_ready = 4'h0;
    chk("steer_drained", int'(out_valid), 0);
    // full and back-pressure on channel 2 only
    send(2, 1);
    send(2, 2);
    chk("full_occ2", int'(occ2), 2);
    in_valid = 1'b1;
    in_sel   = 2'd2;
    in_data  = 2'd3;
    #1;
    chk("full_ready_sel2", int'(in_ready), 0);
    in_sel = 2'd0;
    #1;
    chk("full_ready_sel0", int'(in_ready), 1);
    in_valid = 1'b0;
    out_ready[2] = 1'b1;
    step(1);
    chk("drain1_occ2", int'(occ2), 1);
    chk("drain1_d2", int'(out_data2), 2);
    step(1);
    chk("drain2_occ2", int'(occ2), 0);
    chk("drain2_valid2", int'(out_valid[2]), 0);
    out_ready = 4'h0;
    // simultaneous accept and drain on channel 1 at count 1
    send(1, 2);
    out_ready[1] = 1'b1;
    send(1, 3);
    chk("simul_occ1", int'(occ1), 1);
    chk("simul_d1", int'(out_data1), 3);
    step(1);
    out_ready = 4'h0;
    chk("simul_empty", int'(occ1), 0);
    // streaming into channel 3 with consumer always ready
    out_ready[3] = 1'b1;
    for (int k = 0; k < 16; k++) begin
      send(3, (k * 3 + 1) % 4);
      chk("stream_occ3_le1", int'(occ3 <= 2'd1), 1);
    end
    step(1);
    out_ready = 4'h0;
    chk("stream_done", int'(out_valid), 0);
    // reset while channels 0 and 2 are full
    send(0, 1);
    send(0, 2);
    send(2, 3);
    send(2, 0);
    chk("pre_reset_occ0", int'(occ0), 2);
    chk("pre_reset_occ2", int'(occ2), 2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("mid_reset_valid", int'(out_valid), 0);
    chk("mid_reset_occ0", int'(occ0), 0);
    chk("mid_reset_occ2", int'(occ2), 0);
    out_ready = 4'hf;
    send(2, 1);
    chk("post_reset_valid", int'(out_valid), 4);
    chk("post_reset_d2", int'(out_data2), 1);
    step(1);
    out_ready = 4'h0;
    chk("all_drained", expq[0].size() + expq[1].size() + expq[2].size() + expq[3].size(), 0);
    // asynchronous reset with the clock stopped
    send(1, 3);
    send(0, 2);
    run = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk("async_valid", int'(out_valid), 0);
    chk("async_ready", int'(in_ready), 1);
    chk("async_occ", int'({occ0, occ1, occ2, occ3}), 0);
    chk("async_data", int'({out_data0, out_data1, out_data2, out_data3}), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
